// File: rtl/timer_regfile.sv
// -----------------------------------------------------------------------------
// timer_regfile
//   Host-facing register file for a single timer. It decodes a small 4-word
//   bus, gives the timer its start/halt pulses, mode and terminal count, reads
//   back the timer state, and turns the timer's terminal-count event into a
//   sticky interrupt flag that the host clears by writing 1 to it.
//
//   Register map (word-decoded from bus_addr[3:2]):
//     0x0 CTRL      W: bit0 start (pulse), bit1 halt (pulse), bit2 mode,
//                      bit3 int_enable (mask build only)
//                   R: {28'b0, int_enable|0, mode, 2'b0}
//     0x4 TERMCOUNT RW, drives ro_termcount
//     0x8 STATUS    R: {30'b0, int_pending, rf_status}; W: bit1 = 1 clears
//                      int_pending
//     0xC CURRCOUNT R: rf_currcount sampled on the strobe cycle
//
//   Build option: define TIMER_REGFILE_IRQ_MASK_EN to add the CTRL bit3
//   interrupt enable (reset 0) that gates irq. Without it irq = int_pending.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous active-low reset
//   bus_wr        in   write strobe, one cycle per access
//   bus_rd        in   read strobe, one cycle per access
//   bus_addr      in   [3:0] byte address, bits [1:0] ignored
//   bus_wdata     in   [31:0] write data
//   bus_rdata     out  [31:0] read data, valid with bus_ack, 0 otherwise
//   bus_ack       out  access-complete pulse, cycle after the strobe
//   ro_trig_start out  timer start pulse
//   ro_trig_halt  out  timer halt pulse
//   ro_mode       out  timer mode (1 = auto-reload)
//   ro_termcount  out  [31:0] timer terminal count
//   rf_status     in   timer running
//   rf_currcount  in   [31:0] timer current count
//   rf_int        in   timer terminal-count event (level or pulse)
//   irq           out  registered interrupt request to host
// -----------------------------------------------------------------------------
module timer_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_wr,
  input  logic        bus_rd,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        ro_trig_start,
  output logic        ro_trig_halt,
  output logic        ro_mode,
  output logic [31:0] ro_termcount,
  input  logic        rf_status,
  input  logic [31:0] rf_currcount,
  input  logic        rf_int,
  output logic        irq
);

  localparam logic [1:0] ADDR_CTRL      = 2'd0;
  localparam logic [1:0] ADDR_TERMCOUNT = 2'd1;
  localparam logic [1:0] ADDR_STATUS    = 2'd2;
  localparam logic [1:0] ADDR_CURRCOUNT = 2'd3;

  logic        r_ack;
  logic [31:0] r_rdata;
  logic        r_trig_start;
  logic        r_trig_halt;
  logic        r_mode;
  logic [31:0] r_termcount;
  logic        r_int_d;
  logic        r_int_pending;
  logic        r_irq;

  logic [1:0]  w_word;
  logic        w_strobe;
  logic        w_rd_only;
  logic        w_wr_ctrl;
  logic        w_wr_termcount;
  logic        w_int_rise;
  logic        w_int_clr;
  logic        w_int_en;
  logic [31:0] w_rdata_mux;
  logic        w_unused;

  // Byte-lane bits of the address carry no meaning in a word-only map.
  assign w_unused = ^bus_addr[1:0];

  assign w_word         = bus_addr[3:2];
  assign w_strobe       = bus_wr | bus_rd;
  // A simultaneous write wins; the read half is dropped and rdata stays 0.
  assign w_rd_only      = bus_rd & ~bus_wr;
  assign w_wr_ctrl      = bus_wr & (w_word == ADDR_CTRL);
  assign w_wr_termcount = bus_wr & (w_word == ADDR_TERMCOUNT);
  // Edge detect so a level-style rf_int only raises one event per assertion.
  assign w_int_rise     = rf_int & ~r_int_d;
  assign w_int_clr      = bus_wr & (w_word == ADDR_STATUS) & bus_wdata[1];

`ifdef TIMER_REGFILE_IRQ_MASK_EN
  logic r_int_en;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_int_en <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_int_en <= bus_wdata[3];
    end
  end

  assign w_int_en = r_int_en;
`else
  assign w_int_en = 1'b1;
`endif

  // Read mux: values are taken on the strobe cycle and registered, so the
  // data returned with bus_ack reflects the state at the time of the request.
  always_comb begin
    w_rdata_mux = 32'd0;
    case (w_word)
      ADDR_CTRL: begin
        w_rdata_mux[2] = r_mode;
`ifdef TIMER_REGFILE_IRQ_MASK_EN
        w_rdata_mux[3] = r_int_en;
`endif
      end
      ADDR_TERMCOUNT: w_rdata_mux = r_termcount;
      ADDR_STATUS:    w_rdata_mux = {30'd0, r_int_pending, rf_status};
      ADDR_CURRCOUNT: w_rdata_mux = rf_currcount;
      default:        w_rdata_mux = 32'd0;
    endcase
  end

  // Bus response, timer controls and interrupt flag; all one cycle after the
  // strobe that caused them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ack         <= 1'b0;
      r_rdata       <= 32'd0;
      r_trig_start  <= 1'b0;
      r_trig_halt   <= 1'b0;
      r_mode        <= 1'b0;
      r_termcount   <= 32'd0;
      r_int_d       <= 1'b0;
      r_int_pending <= 1'b0;
      r_irq         <= 1'b0;
    end else begin
      r_ack        <= w_strobe;
      r_rdata      <= w_rd_only ? w_rdata_mux : 32'd0;
      // Halt takes priority: a start+halt write only halts.
      r_trig_halt  <= w_wr_ctrl & bus_wdata[1];
      r_trig_start <= w_wr_ctrl & bus_wdata[0] & ~bus_wdata[1];
      if (w_wr_ctrl) begin
        r_mode <= bus_wdata[2];
      end
      if (w_wr_termcount) begin
        r_termcount <= bus_wdata;
      end
      r_int_d <= rf_int;
      // A new event arriving with the clear must not be lost: set wins.
      if (w_int_rise) begin
        r_int_pending <= 1'b1;
      end else if (w_int_clr) begin
        r_int_pending <= 1'b0;
      end
      r_irq <= r_int_pending & w_int_en;
    end
  end

  assign bus_ack       = r_ack;
  assign bus_rdata     = r_rdata;
  assign ro_trig_start = r_trig_start;
  assign ro_trig_halt  = r_trig_halt;
  assign ro_mode       = r_mode;
  assign ro_termcount  = r_termcount;
  assign irq           = r_irq;

endmodule

// File: tb/tb_timer_regfile.sv
module tb_timer_regfile;

  logic        clk;
  logic        reset;
  logic        bus_wr;
  logic        bus_rd;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        ro_trig_start;
  logic        ro_trig_halt;
  logic        ro_mode;
  logic [31:0] ro_termcount;
  logic        rf_status;
  logic [31:0] rf_currcount;
  logic        rf_int;
  logic        irq;

  timer_regfile dut (
    .clk           (clk),
    .reset         (reset),
    .bus_wr        (bus_wr),
    .bus_rd        (bus_rd),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .bus_ack       (bus_ack),
    .ro_trig_start (ro_trig_start),
    .ro_trig_halt  (ro_trig_halt),
    .ro_mode       (ro_mode),
    .ro_termcount  (ro_termcount),
    .rf_status     (rf_status),
    .rf_currcount  (rf_currcount),
    .rf_int        (rf_int),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the register state.
  logic [31:0] m_tc;
  logic        m_mode;
  logic        m_pend;
  logic        m_en;      // effective irq enable
  logic [31:0] sb[$];

`ifdef TIMER_REGFILE_IRQ_MASK_EN
  localparam logic [31:0] EN_BIT = 32'h8;
  localparam logic        EN_RST = 1'b0;
`else
  localparam logic [31:0] EN_BIT = 32'h0;
  localparam logic        EN_RST = 1'b1;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (a[3:2])
      2'd0: v = {28'd0, (EN_BIT != 0) ? m_en : 1'b0, m_mode, 2'b00};
      2'd1: v = m_tc;
      2'd2: v = {30'd0, m_pend, rf_status};
      default: v = rf_currcount;
    endcase
    return v;
  endfunction

  task automatic model_write(input logic [3:0] a, input logic [31:0] wd);
    case (a[3:2])
      2'd0: begin
        m_mode = wd[2];
        if (EN_BIT != 0) m_en = wd[3];
      end
      2'd1: m_tc = wd;
      2'd2: if (wd[1]) m_pend = 1'b0;
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_tc = 32'd0; m_mode = 1'b0; m_pend = 1'b0; m_en = EN_RST;
  endtask

  // One bus access: push the expected rdata, clock the strobe in, then pop
  // and compare against the data returned with the ack.
  task automatic bus(input logic wr, input logic rd, input logic [3:0] a,
                     input logic [31:0] wd, input string tag);
    logic [31:0] exp;
    bus_wr = wr; bus_rd = rd; bus_addr = a; bus_wdata = wd;
    if (rd && !wr) sb.push_back(model_read(a));
    else sb.push_back(32'd0);
    if (wr) model_write(a, wd);
    step();
    bus_wr = 1'b0; bus_rd = 1'b0;
    chk({tag, "_ack"}, {31'd0, bus_ack}, 32'd1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      chk({tag, "_rdata"}, bus_rdata, exp);
    end else begin
      chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0; bus_wr = 1'b0; bus_rd = 1'b0; bus_addr = 4'd0; bus_wdata = 32'd0;
    rf_status = 1'b0; rf_currcount = 32'd0; rf_int = 1'b0;
    model_reset();

    // Reset state
    step(); step();
    chk("rst_ack", {31'd0, bus_ack}, 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    chk("rst_start", {31'd0, ro_trig_start}, 32'd0);
    chk("rst_halt", {31'd0, ro_trig_halt}, 32'd0);
    chk("rst_mode", {31'd0, ro_mode}, 32'd0);
    chk("rst_tc", ro_termcount, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b1;
    step();

    // TERMCOUNT write and read-back
    bus(1'b1, 1'b0, 4'h4, 32'd10, "wr_tc");
    chk("tc_out", ro_termcount, m_tc);
    bus(1'b0, 1'b1, 4'h4, 32'd0, "rd_tc");
    chk("rd_tc_val", bus_rdata, 32'h0000000A);
    step();
    chk("ack_single", {31'd0, bus_ack}, 32'd0);
    chk("rdata_idle", bus_rdata, 32'd0);

    // CTRL start + mode
    bus(1'b1, 1'b0, 4'h0, 32'h5 | EN_BIT, "wr_ctrl5");
    chk("start_pulse", {31'd0, ro_trig_start}, 32'd1);
    chk("halt_quiet", {31'd0, ro_trig_halt}, 32'd0);
    chk("mode_set", {31'd0, ro_mode}, 32'd1);
    step();
    chk("start_one_cycle", {31'd0, ro_trig_start}, 32'd0);
    bus(1'b0, 1'b1, 4'h0, 32'd0, "rd_ctrl");
    chk("rd_ctrl_val", bus_rdata, 32'h4 | EN_BIT);

    // CTRL start + halt: halt only
    bus(1'b1, 1'b0, 4'h0, 32'h3 | EN_BIT, "wr_ctrl3");
    chk("halt_pulse", {31'd0, ro_trig_halt}, 32'd1);
    chk("start_suppr", {31'd0, ro_trig_start}, 32'd0);
    chk("mode_clr", {31'd0, ro_mode}, 32'd0);
    step();
    chk("halt_one_cycle", {31'd0, ro_trig_halt}, 32'd0);
    chk("start_after", {31'd0, ro_trig_start}, 32'd0);

    // STATUS / CURRCOUNT reads, ignored CURRCOUNT write
    rf_status = 1'b1;
    bus(1'b0, 1'b1, 4'h8, 32'd0, "rd_status");
    rf_currcount = 32'h12345678;
    bus(1'b0, 1'b1, 4'hC, 32'd0, "rd_curr");
    rf_currcount = 32'hDEADBEEF;
    bus(1'b1, 1'b0, 4'hC, 32'hFFFFFFFF, "wr_curr");
    bus(1'b0, 1'b1, 4'h4, 32'd0, "rd_tc2");

    // Interrupt: edge -> pending -> irq, then W1C
    rf_int = 1'b1;
    step();
    m_pend = 1'b1;
    chk("irq_lag", {31'd0, irq}, 32'd0);
    step();
    chk("irq_set", {31'd0, irq}, {31'd0, m_pend & m_en});
    bus(1'b0, 1'b1, 4'h8, 32'd0, "rd_status_pend");
    bus(1'b1, 1'b0, 4'h8, 32'h2, "w1c");
    step();
    chk("irq_clr", {31'd0, irq}, 32'd0);
    step();
    chk("irq_level_no_reset", {31'd0, irq}, 32'd0);

    // Set and clear on the same cycle: set wins
    rf_int = 1'b0;
    step();
    rf_int = 1'b1;
    bus(1'b1, 1'b0, 4'h8, 32'h2, "w1c_race");
    m_pend = 1'b1;
    bus(1'b0, 1'b1, 4'h8, 32'd0, "rd_status_race");
    rf_int = 1'b0;
    bus(1'b1, 1'b0, 4'h8, 32'h2, "w1c2");
    step();

    // Simultaneous write and read: write wins, single ack, no read data
    bus(1'b1, 1'b1, 4'h4, 32'h55, "wr_rd");
    chk("wr_rd_tc", ro_termcount, 32'h55);
    step();
    chk("wr_rd_ack_single", {31'd0, bus_ack}, 32'd0);

    // Reset after a start strobe aborts everything
    bus_wr = 1'b1; bus_addr = 4'h0; bus_wdata = 32'h1;
    step();
    bus_wr = 1'b0;
    reset = 1'b0;
    step();
    model_reset();
    chk("abort_ack", {31'd0, bus_ack}, 32'd0);
    chk("abort_start", {31'd0, ro_trig_start}, 32'd0);
    chk("abort_rdata", bus_rdata, 32'd0);
    chk("abort_tc", ro_termcount, 32'd0);
    chk("abort_mode", {31'd0, ro_mode}, 32'd0);
    chk("abort_irq", {31'd0, irq}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rel_start", {31'd0, ro_trig_start}, 32'd0);
      chk("post_rel_ack", {31'd0, bus_ack}, 32'd0);
    end

    // rf_int held high through reset release sets pending right after
    rf_int = 1'b1;
    reset = 1'b0;
    step();
    model_reset();
    reset = 1'b1;
    step();
    m_pend = 1'b1;
    bus(1'b0, 1'b1, 4'h8, 32'd0, "rd_status_rel");
    chk("irq_rel", {31'd0, irq}, {31'd0, m_pend & m_en});
    rf_int = 1'b0;
    step();

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/timer_regfile.md
TIMER_REGFILE -- requirements
Module: timer_regfile

Interface
REQ-001 SHALL have one clock and a synchronous active-low reset; no other clocks.
REQ-002 SHALL expose ports (name  dir  width  meaning):
 clk  in  1  rising-edge clock
 reset  in  1  synchronous active-low reset
 bus_wr  in  1  write strobe, one cycle per access
 bus_rd  in  1  read strobe, one cycle per access
 bus_addr  in  4  byte address; bits [1:0] ignored
 bus_wdata  in  32  write data
 bus_rdata  out  32  read data, valid with bus_ack
 bus_ack  out  1  access-complete pulse
 ro_trig_start  out  1  timer start pulse
 ro_trig_halt  out  1  timer halt pulse
 ro_mode  out  1  timer mode (1 = auto-reload)
 ro_termcount  out  32  timer terminal count
 rf_status  in  1  timer running
 rf_currcount  in  32  timer current count
 rf_int  in  1  timer terminal-count event (level or pulse)
 irq  out  1  interrupt request to host

Function
REQ-003 Register map: 0x0 CTRL, 0x4 TERMCOUNT, 0x8 STATUS, 0xC CURRCOUNT.
REQ-004 CTRL write: bit0 = 1 starts, bit1 = 1 halts (both self-clearing), bit2 = mode (RW); CTRL read: {29'b0, mode, 2'b0}.
REQ-005 TERMCOUNT SHALL be fully RW, driving ro_termcount directly.
REQ-006 STATUS read: {30'b0, int_pending, rf_status}; writing 1 to bit1 clears int_pending; all other bits ignore writes.
REQ-007 CURRCOUNT read returns rf_currcount sampled on the strobe cycle; writes ignored.
REQ-008 bus_ack SHALL pulse exactly one cycle, on the cycle after bus_wr or bus_rd; bus_rdata valid on that cycle, 0 otherwise.
REQ-009 bus_wr and bus_rd asserted together: write performed, read ignored, single ack.
REQ-010 ro_trig_start / ro_trig_halt SHALL be one-cycle pulses, asserted the cycle after the CTRL write strobe (concurrent with bus_ack).
REQ-011 CTRL write with bit0 and bit1 both 1: only halt pulses; start suppressed.
REQ-012 int_pending SHALL set on the cycle after a 0->1 transition of rf_int (edge detect via registered rf_int).
REQ-013 Set event and W1C on the same cycle: int_pending remains 1 (set wins).
REQ-014 irq SHALL be registered, equal to int_pending (gated per REQ-019); one cycle behind int_pending.
REQ-015 Access to unmapped address impossible (4 words, 2 bits decoded); no error response.

Reset
REQ-016 While reset = 0 at a clk edge: bus_ack, bus_rdata, ro_trig_start, ro_trig_halt, ro_mode, irq = 0; ro_termcount = 0; int_pending = 0; rf_int edge register = 0.
REQ-017 Reset asserted mid-access SHALL abort the access: no ack, no trigger pulse after reset release.
REQ-018 rf_int held high through reset release SHALL set int_pending on the first cycle after release (edge register reset to 0).

Configuration
REQ-019 Macro TIMER_REGFILE_IRQ_MASK_EN: defined -> CTRL bit3 is RW int_enable (reset 0), irq = int_pending & int_enable, CTRL read includes bit3; undefined -> CTRL bit3 reads 0, irq = int_pending.

Verification
REQ-020 Write TERMCOUNT=10, read back -> bus_rdata=0x0000000A with ack one cycle after strobe; ro_termcount=10.
REQ-021 Write CTRL=0x5 -> ro_mode=1, ro_trig_start high one cycle, ro_trig_halt stays 0; CTRL read = 0x4.
REQ-022 Write CTRL=0x3 -> ro_trig_halt one-cycle pulse, ro_trig_start never asserted.
REQ-023 Drive rf_int 0->1 -> int_pending=1 next cycle, irq=1 one cycle later (mask enabled if macro defined); STATUS write 0x2 -> irq drops to 0.
REQ-024 rf_int rising on same cycle as STATUS write 0x2 -> STATUS read returns bit1=1.
REQ-025 Assert reset one cycle after CTRL=0x1 write strobe -> no ro_trig_start pulse, bus_ack 0, all outputs 0.
